// File: rtl/bpu_update_ctrl_pkg.sv
// bpu_update_ctrl_pkg
// Shared definitions for the branch-predictor update controller:
//   - FSM state encodings (IDLE / DRAIN / CLEAR)
//   - default resolution FIFO depth and predictor table size
//   - the buffered resolution entry layout
//   - ZERO_WORD / JUMP_ENABLE constants reused across the core
package bpu_update_ctrl_pkg;

  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic        JUMP_ENABLE = 1'b1;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_ENTRIES = 32;
  localparam int DEF_IDX_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } bpu_state_e;

  // One buffered resolved-branch report.
  typedef struct packed {
    logic [31:0] addr;
    logic        taken;
  } res_entry_t;

endpackage

// File: rtl/bpu_update_ctrl_if.sv
// bpu_update_ctrl_if
// Groups the EX resolution report and the predictor table write port.
//   res_valid_i, res_is_branch_i, res_addr_i, res_taken_i, res_pred_i : EX report
//   tbl_we_o, tbl_clear_o, tbl_addr_o, tbl_taken_o                    : table write
//   tbl_ready_i                                                       : table accepts
// Handshake: a table write transfers on the cycle where tbl_we_o & tbl_ready_i;
// while tbl_we_o=1 and tbl_ready_i=0 the payload (tbl_clear_o, tbl_addr_o,
// tbl_taken_o) is held stable; tbl_ready_i with tbl_we_o=0 has no effect.
// modport master: the update controller; modport slave: EX/predictor side.
interface bpu_update_ctrl_if;
  logic        res_valid_i;
  logic        res_is_branch_i;
  logic [31:0] res_addr_i;
  logic        res_taken_i;
  logic        res_pred_i;

  logic        tbl_we_o;
  logic        tbl_clear_o;
  logic [31:0] tbl_addr_o;
  logic        tbl_taken_o;
  logic        tbl_ready_i;

  modport master (
    input  res_valid_i, res_is_branch_i, res_addr_i, res_taken_i, res_pred_i,
    input  tbl_ready_i,
    output tbl_we_o, tbl_clear_o, tbl_addr_o, tbl_taken_o
  );

  modport slave (
    output res_valid_i, res_is_branch_i, res_addr_i, res_taken_i, res_pred_i,
    output tbl_ready_i,
    input  tbl_we_o, tbl_clear_o, tbl_addr_o, tbl_taken_o
  );
endinterface

// File: rtl/bpu_res_fifo.sv
// bpu_res_fifo
// Registered show-ahead FIFO. The head entry is presented on rdata whenever
// empty=0; an entry pushed at edge N is visible from cycle N+1.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry
//   full, empty, count : occupancy (count is 0..DEPTH)
// DEPTH must be a power of 2 so pointers wrap naturally.
module bpu_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl
// Sequences every write into the branch predictor tables. Resolved-branch
// reports from EX are buffered in bpu_res_fifo and issued one at a time over
// the single table write port; a clear request drains the buffer and then
// sweeps every table index with clear writes.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : EX report inputs and table write port
//   clear_req_i    : request a full table clear (honoured only in IDLE)
//   busy_o         : FSM not in IDLE
//   clear_done_o   : one-cycle pulse after the last clear write
//   overflow_o     : sticky, a report was dropped
//   branch_cnt_o   : saturating count of reported branches
//   mispred_cnt_o  : saturating count of reported mispredicts
//   state_o        : current FSM state (debug)
// Build option: BPU_PERF_CNT_EN implements the two statistics counters;
// without it they read as zero and no counter flops exist.
module bpu_update_ctrl
  import bpu_update_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  bpu_update_ctrl_if.master  bus,
  input  logic               clear_req_i,
  output logic               busy_o,
  output logic               clear_done_o,
  output logic               overflow_o,
  output logic [31:0]        branch_cnt_o,
  output logic [31:0]        mispred_cnt_o,
  output bpu_state_e         state_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  bpu_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             ovf_q;

  logic             report;
  logic             enq;
  logic             deq;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  res_entry_t       head;
  res_entry_t       new_entry;

  logic             we;
  logic             clr;
  logic [31:0]      addr;
  logic             taken;

  assign report    = bus.res_valid_i & bus.res_is_branch_i;
  // Full blocks enqueue even if the head leaves in the same cycle.
  assign enq       = report & (state_q == ST_IDLE) & ~fifo_full;
  assign new_entry = '{addr: bus.res_addr_i, taken: bus.res_taken_i};

  bpu_res_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(res_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (deq),
    .wdata (new_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (report && !enq) ovf_q <= 1'b1;
    end
  end

  // Transfers are derived from tbl_ready_i directly rather than from the
  // registered-looking tbl_we_o so this block has no self-dependency.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    we      = 1'b0;
    clr     = 1'b0;
    addr    = ZERO_WORD;
    taken   = 1'b0;
    deq     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we    = ~fifo_empty;
        addr  = head.addr;
        taken = head.taken;
        deq   = ~fifo_empty & bus.tbl_ready_i;
        if (clear_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        we    = ~fifo_empty;
        addr  = head.addr;
        taken = head.taken;
        deq   = ~fifo_empty & bus.tbl_ready_i;
        // Sweep starts only once no queued update remains outstanding.
        if (fifo_count == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        we   = JUMP_ENABLE;
        clr  = 1'b1;
        addr = 32'(idx_q);
        if (bus.tbl_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.tbl_we_o    = we;
  assign bus.tbl_clear_o = clr;
  assign bus.tbl_addr_o  = addr;
  assign bus.tbl_taken_o = taken;

  assign busy_o       = (state_q != ST_IDLE);
  assign clear_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign state_o      = state_q;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] bcnt_q;
  logic [31:0] mcnt_q;

  // Every branch report counts, including ones that get dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= ZERO_WORD;
      mcnt_q <= ZERO_WORD;
    end else begin
      if (report && (bcnt_q != 32'hFFFF_FFFF))
        bcnt_q <= bcnt_q + 32'd1;
      if (report && (bus.res_taken_i != bus.res_pred_i) && (mcnt_q != 32'hFFFF_FFFF))
        mcnt_q <= mcnt_q + 32'd1;
    end
  end

  assign branch_cnt_o  = bcnt_q;
  assign mispred_cnt_o = mcnt_q;
`else
  logic unused_pred;
  assign unused_pred   = bus.res_pred_i;
  assign branch_cnt_o  = ZERO_WORD;
  assign mispred_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb_bpu_update_ctrl
// Randomized and directed stimulus for bpu_update_ctrl, scored against a
// queue-based reference model. Table writes are expected in the order they
// were accepted: update entries when a report is accepted, then ENTRIES clear
// entries when a clear request is taken in IDLE.
module tb_bpu_update_ctrl;
  import bpu_update_ctrl_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int M_IDLE  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_CLEAR = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpu_update_ctrl_if bus();
  logic        clear_req;
  logic        busy, done, ovf;
  logic [31:0] bcnt, mcnt;
  bpu_state_e  st;

  bpu_update_ctrl #(.DEPTH(DEPTH), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .clear_req_i   (clear_req),
    .busy_o        (busy),
    .clear_done_o  (done),
    .overflow_o    (ovf),
    .branch_cnt_o  (bcnt),
    .mispred_cnt_o (mcnt),
    .state_o       (st)
  );

  // ---------------- scoreboard / model state ----------------
  logic [33:0] exp_q[$];   // {clear, addr, taken}
  int          m_mode, m_size, m_left;
  bit          m_ovf, m_done;
  logic [31:0] m_bc, m_mc;
  bit          e_busy, e_we, e_done, e_ovf;
  logic [31:0] e_bc, e_mc;
  bit          chk_en, rst_seen;
  int          n_chk, n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: advances one clock using the inputs about to be sampled.
  task automatic model_step(input logic r, input logic v, input logic br,
                            input logic [31:0] a, input logic tk, input logic pd,
                            input logic cr, input logic rdy);
    bit rep;
    if (r) begin
      m_mode = M_IDLE; m_size = 0; m_left = 0;
      m_ovf = 0; m_done = 0; m_bc = '0; m_mc = '0;
      return;
    end
    m_done = 0;
    rep = v & br;
    if (rep && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    if (rep && (tk != pd) && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
    case (m_mode)
      M_IDLE: begin
        bit acc;
        acc = rep && (m_size < DEPTH);
        if (rep && !acc) m_ovf = 1;
        if (m_size > 0 && rdy) m_size--;
        if (acc) begin
          exp_q.push_back({1'b0, a, tk});
          m_size++;
        end
        if (cr) begin
          m_mode = M_DRAIN;
          for (int i = 0; i < ENTRIES; i++) exp_q.push_back({1'b1, 32'(i), 1'b0});
        end
      end
      M_DRAIN: begin
        if (rep) m_ovf = 1;
        if (m_size == 0) begin
          m_mode = M_CLEAR;
          m_left = ENTRIES;
        end else if (rdy) m_size--;
      end
      default: begin
        if (rep) m_ovf = 1;
        if (rdy) begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_done = 1;
          end
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic br,
                      input logic [31:0] a, input logic tk, input logic pd,
                      input logic cr, input logic rdy);
    @(posedge clk); #1;
    // Model now matches the state the DUT just entered.
    chk_en = rst_seen;
    e_busy = (m_mode != M_IDLE);
    e_we   = (m_mode == M_CLEAR) || (m_size > 0);
    e_done = m_done;
    e_ovf  = m_ovf;
`ifdef BPU_PERF_CNT_EN
    e_bc = m_bc; e_mc = m_mc;
`else
    e_bc = '0; e_mc = '0;
`endif
    rst                 = r;
    bus.res_valid_i     = v;
    bus.res_is_branch_i = br;
    bus.res_addr_i      = a;
    bus.res_taken_i     = tk;
    bus.res_pred_i      = pd;
    clear_req           = cr;
    bus.tbl_ready_i     = rdy;
    model_step(r, v, br, a, tk, pd, cr, rdy);
    if (r) rst_seen = 1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, rdy);
  endtask

  task automatic report(input logic [31:0] a, input logic tk, input logic pd, input logic rdy);
    step(0, 1, 1, a, tk, pd, 0, rdy);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(e_busy));
      check("tbl_we", 64'(bus.tbl_we_o), 64'(e_we));
      check("clear_done", 64'(done), 64'(e_done));
      check("overflow", 64'(ovf), 64'(e_ovf));
      check("branch_cnt", 64'(bcnt), 64'(e_bc));
      check("mispred_cnt", 64'(mcnt), 64'(e_mc));
      if (bus.tbl_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL payload: write %0h with empty expected queue at %0t",
                   {bus.tbl_clear_o, bus.tbl_addr_o, bus.tbl_taken_o}, $time);
        end else begin
          check("payload", 64'({bus.tbl_clear_o, bus.tbl_addr_o, bus.tbl_taken_o}), 64'(exp_q[0]));
          if (bus.tbl_ready_i) void'(exp_q.pop_front());
        end
      end
    end
    if (rst === 1'b1) exp_q.delete();
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; clear_req = 0;
    bus.res_valid_i = 0; bus.res_is_branch_i = 0; bus.res_addr_i = '0;
    bus.res_taken_i = 0; bus.res_pred_i = 0; bus.tbl_ready_i = 0;
    n_chk = 0; n_pass = 0; chk_en = 0; rst_seen = 0;
    model_step(1, 0, 0, '0, 0, 0, 0, 0);

    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    idle(2, 1);

    // single update
    report(32'h100, 1, 1, 1);
    idle(3, 1);

    // backpressure: 5 reports into a 4-deep buffer
    for (int i = 0; i < 5; i++) report(32'h200 + 32'(i * 4), 1'(i), 0, 0);
    idle(3, 0);
    idle(6, 1);

    // clear sweep with two queued updates and a report during the sweep
    report(32'h300, 1, 0, 0);
    report(32'h304, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1, 1);
    idle(6, 1);
    report(32'h308, 1, 1, 1);
    idle(34, 1);

    // clear under alternating ready
    step(0, 0, 0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 70; i++) idle(1, 1'(i % 2 == 0));
    idle(4, 1);

    // mispredict counting, then a non-branch
    report(32'h400, 1, 0, 1);
    report(32'h404, 0, 0, 1);
    report(32'h408, 0, 1, 1);
    step(0, 1, 0, 32'h40c, 1, 0, 0, 1);
    idle(3, 1);

    // reset mid-sweep, then a fresh sweep from index 0
    step(0, 0, 0, '0, 0, 0, 1, 1);
    idle(12, 1);
    step(1, 0, 0, '0, 0, 0, 0, 1);
    idle(2, 1);
    step(0, 0, 0, '0, 0, 0, 1, 1);
    idle(36, 1);

    // coincident clear request and report
    step(0, 1, 1, 32'h500, 1, 0, 1, 0);
    idle(40, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));

    idle(120, 1);
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
